// File: rtl/cpu_div_pkg.sv
// rtl/cpu_div_pkg.sv - shared constants and state encoding for the iterative divider
//   DIV_WIDTH   : operand/result width
//   DIV_CNT_W   : iteration counter width
//   div_state_e : control FSM state encoding

package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/divider_32_if.sv
// rtl/divider_32_if.sv - start/busy/done request and result bundle for divider_32
//   start, sign, A, B : request side, driven by the pipeline (master)
//   quo, rem          : registered results, driven by the divider (slave)
//   busy, done        : handshake status, driven by the divider (slave)

interface divider_32_if #(
    parameter int WIDTH = cpu_div_pkg::DIV_WIDTH
);

    logic             start;
    logic             sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;

    modport master (
        output start, sign, A, B,
        input  quo, rem, busy, done
    );

    modport slave (
        input  start, sign, A, B,
        output quo, rem, busy, done
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
//   rem_in  : partial remainder (WIDTH+1 bits)
//   divisor : divisor magnitude
//   bit_in  : next dividend bit, shifted into the remainder LSB
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this iteration

module div_step #(
    parameter int WIDTH = cpu_div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], bit_in};
        diff    = shifted - {1'b0, divisor};
        // A bit pushed out of the top means the true shifted value already
        // exceeds any divisor, so the subtraction must be kept.
        q_bit   = rem_in[WIDTH] | ~diff[WIDTH];
        rem_out = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/divider_32.sv
// rtl/divider_32.sv - iterative signed/unsigned restoring divider, one quotient bit per clock
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : divider_32_if.slave (start/sign/A/B in, quo/rem/busy/done out)

module divider_32
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    divider_32_if.slave  bus
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q;     // dividend magnitude, becomes the quotient as bits shift in
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic [WIDTH-1:0] a_q;       // original dividend, returned as remainder on divide-by-zero
    logic [WIDTH:0]   prem_q;    // partial remainder
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q, rneg_q, dz_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic             can_accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .divisor (dvs_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        can_accept = 1'b0;
        case (state_q)
            IDLE: begin
                can_accept = 1'b1;
                if (bus.start) state_d = CALC;
            end
            CALC: if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                can_accept = 1'b1;
                state_d    = bus.start ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (can_accept && bus.start) begin
            // Negating 0x80000000 yields 0x80000000, read as an unsigned magnitude.
            dvd_q  <= (bus.sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
            dvs_q  <= (bus.sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;
            a_q    <= bus.A;
            qneg_q <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rneg_q <= bus.sign & bus.A[WIDTH-1];
            dz_q   <= (bus.B == '0);
            prem_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == CALC) begin
            dvd_q  <= {dvd_q[WIDTH-2:0], step_q};
            prem_q <= step_rem;
            cnt_q  <= cnt_q + 1'b1;
        end else if (state_q == FIX) begin
            quo_q <= dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
            rem_q <= dz_q ? a_q : (rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0]);
        end
    end

    assign bus.quo  = quo_q;
    assign bus.rem  = rem_q;
    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_divider_32.sv
// tb/tb_divider_32.sv - directed self-checking bench for divider_32

module tb_divider_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    divider_32_if #(.WIDTH(32)) bus ();

    divider_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [31:0] quo;
        logic [31:0] rem;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the negedge of cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.sign  = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered at the negedge of cycle cyc0 of an operation; waits for done.
    task automatic finish_op(input string nm, input int cyc0,
                             input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        bit busy_ok;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, 32'(cyc), 32'd34);
        check({nm, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({nm, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({nm, " quo"}, bus.quo, eq);
        check({nm, " rem"}, bus.rem, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        //        a             b             sign  quo           rem
        vecs.push_back('{32'd100,      32'd7,        1'b0, 32'd14,       32'd2});
        vecs.push_back('{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE});
        // 4294967196 = 7 * 613566742 + 2
        vecs.push_back('{32'hFFFFFF9C, 32'd7,        1'b0, 32'h24924916, 32'd2});
        vecs.push_back('{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678});
        vecs.push_back('{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678});
        vecs.push_back('{32'hFFFFFFF0, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1});
        vecs.push_back('{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF});
        vecs.push_back('{32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0});
        vecs.push_back('{32'd5,        32'd9,        1'b0, 32'd0,        32'd5});
        vecs.push_back('{32'd0,        32'd5,        1'b1, 32'd0,        32'd0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset quo",  bus.quo, 32'd0);
        check("reset rem",  bus.rem, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sign);
            finish_op($sformatf("vec%0d", i), 1, vecs[i].quo, vecs[i].rem);
        end

        // start re-pulsed with new operands mid-operation is ignored
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        bus.A     = 32'd5000;
        bus.B     = 32'd3;
        bus.sign  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("ignore_start", 11, 32'd14, 32'd2);

        // start held through DONE launches the next operation back-to-back
        launch(32'd1000, 32'd10, 1'b0);
        repeat (32) @(negedge clk);
        bus.A     = 32'hFFFFFFF9;
        bus.B     = 32'd2;
        bus.sign  = 1'b1;
        bus.start = 1'b1;
        finish_op("b2b_first", 33, 32'd100, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("b2b_second", 1, 32'hFFFFFFFD, 32'hFFFFFFFF);

        // reset mid-operation discards the operation
        launch(32'd12345, 32'd100, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst quo",  bus.quo, 32'd0);
        check("midrst rem",  bus.rem, 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        check("midrst no_done", {31'd0, done_seen}, 32'd0);
        launch(32'd12345, 32'd100, 1'b0);
        finish_op("after_rst", 1, 32'd123, 32'd45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
